// File: rtl/sar_search_4bit_if.sv
// Bundle between the successive-approximation search engine and its environment:
// the start/busy/done/result handshake plus the magnitude-comparator connection
// (guess drives comparator b, the gt/lt/eq flags come back).
// master: the side that issues start and owns the comparator.
// slave: the search engine.
interface sar_search_4bit_if #(
  parameter int WIDTH = 4
);
  localparam int PW = $clog2(WIDTH + 1);

  logic             start;
  logic             cmp_gt;
  logic             cmp_lt;
  logic             cmp_eq;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [PW-1:0]    probes;
  logic             err;

  modport master (
    output start, cmp_gt, cmp_lt, cmp_eq,
    input  guess, busy, done, result, probes, err
  );

  modport slave (
    input  start, cmp_gt, cmp_lt, cmp_eq,
    output guess, busy, done, result, probes, err
  );
endinterface

// File: rtl/sar_search_4bit.sv
// Successive-approximation search engine.
// Drives a candidate onto the comparator b input and binary-searches the unknown
// target on its a input, one probe per clock, at most WIDTH probes per search.
// An equal flag ends the search early; otherwise the last bit decision resolves it.
// Flag priority in PROBE: eq, then lt, then gt; no flag behaves like lt.
// Optional build macro SAR_ONEHOT_CHECK_EN: every PROBE cycle requires exactly one
// comparator flag; a violation sets a sticky err, aborts with done=1 and result=0.
// err is cleared by the next accepted start or by reset. Without the macro err is 0.
module sar_search_4bit #(
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  sar_search_4bit_if.slave  bus
);

  localparam int PW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] TOP_GUESS = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IW-1:0]    TOP_IDX   = IW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    PROBE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [PW-1:0]    probes_q, probes_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Bit decision helpers for the current probe.
  logic             keep_w;      // current bit stays set (target above guess)
  logic             viol_w;      // comparator flags not one-hot
  logic             last_w;      // current probe is on bit 0
  logic             finish_w;    // this PROBE cycle ends the search
  logic [WIDTH-1:0] resolved_w;  // guess with the current bit decided
  logic [WIDTH-1:0] probe_w;     // resolved guess with the next lower bit trial-set

  // Only a clean "greater" keeps the bit; lt, no flag or contradictory flags clear it.
  assign keep_w = bus.cmp_gt & ~bus.cmp_lt;
  assign last_w = (idx_q == '0);

`ifdef SAR_ONEHOT_CHECK_EN
  assign viol_w = ({bus.cmp_gt, bus.cmp_lt, bus.cmp_eq} != 3'b001) &&
                  ({bus.cmp_gt, bus.cmp_lt, bus.cmp_eq} != 3'b010) &&
                  ({bus.cmp_gt, bus.cmp_lt, bus.cmp_eq} != 3'b100);
`else
  assign viol_w = 1'b0;
`endif

  assign finish_w = viol_w | bus.cmp_eq | last_w;

  // Per-bit resolve of the current bit and trial-set of the bit below it.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign resolved_w[gi] = (32'(idx_q) == gi) ? keep_w : guess_q[gi];
      if (gi < WIDTH - 1) begin : g_low
        assign probe_w[gi] = (32'(idx_q) == gi + 1) ? 1'b1 : resolved_w[gi];
      end else begin : g_top
        assign probe_w[gi] = resolved_w[gi];
      end
    end
  endgenerate

  // State register; reset mid-search drops straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: guess, bit index, probe count, result, done pulse, err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guess_q  <= '0;
      idx_q    <= '0;
      probes_q <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      guess_q  <= guess_d;
      idx_q    <= idx_d;
      probes_q <= probes_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: start is only looked at in IDLE, so it is ignored while busy.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = PROBE;
      PROBE:   if (finish_w)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the datapath registers; done is a single-cycle pulse.
  always_comb begin
    guess_d  = guess_q;
    idx_d    = idx_q;
    probes_d = probes_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          guess_d  = TOP_GUESS;
          idx_d    = TOP_IDX;
          probes_d = '0;
          err_d    = 1'b0;
        end
      end
      PROBE: begin
        probes_d = probes_q + PW'(1);
        if (viol_w) begin
          result_d = '0;
          done_d   = 1'b1;
          err_d    = 1'b1;
        end else if (bus.cmp_eq) begin
          result_d = guess_q;
          done_d   = 1'b1;
        end else if (last_w) begin
          guess_d  = resolved_w;
          result_d = resolved_w;
          done_d   = 1'b1;
        end else begin
          guess_d  = probe_w;
          idx_d    = idx_q - IW'(1);
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Outputs: busy follows the state register, everything else is a register copy.
  always_comb begin
    bus.busy   = (state_q == PROBE);
    bus.guess  = guess_q;
    bus.done   = done_q;
    bus.result = result_q;
    bus.probes = probes_q;
`ifdef SAR_ONEHOT_CHECK_EN
    bus.err    = err_q;
`else
    bus.err    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_sar_search_4bit.sv
// Directed bench for the 4-bit successive-approximation search engine.
// A behavioural comparator answers for the target in tgt; bad forces gt=lt=1.
module tb_sar_search_4bit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tgt = 0;
  bit   bad = 1'b0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  sar_search_4bit_if #(.WIDTH(4)) bus ();

  sar_search_4bit #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural magnitude comparator: a = tgt, b = guess.
  always_comb begin
    if (bad) begin
      bus.cmp_gt = 1'b1;
      bus.cmp_lt = 1'b1;
      bus.cmp_eq = 1'b0;
    end else begin
      bus.cmp_gt = (tgt > int'(bus.guess));
      bus.cmp_lt = (tgt < int'(bus.guess));
      bus.cmp_eq = (tgt == int'(bus.guess));
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs == exp) begin
      pass_cnt++;
      $display("check %-14s got %0d exp %0d ok", tag, obs, exp);
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One search: seq holds expected guesses, first probe in the top nibble.
  task automatic run(input string tag, input int target, input logic [15:0] seq,
                     input int nseq, input int exp_result, input int exp_probes,
                     input bit poke, input int bad_probe);
    int k = 0;
    bit fin = 1'b0;
    logic [3:0] exp_g;
    tgt = target;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 0; c < 12 && !fin; c++) begin
      @(negedge clk);
      bus.start = (poke && c == 1);
      if (bus.done) begin
        fin = 1'b1;
      end else if (bus.busy) begin
        if (k < nseq) begin
          exp_g = seq[15 - 4*k -: 4];
          check($sformatf("%s_g%0d", tag, k), int'(bus.guess), int'(exp_g));
        end
        k++;
        bad = (k == bad_probe);
      end
    end
    bad = 1'b0;
    bus.start = 1'b0;
    check({tag, "_done"}, int'(fin), 1);
    check({tag, "_ncyc"}, k, nseq);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_res"}, int'(bus.result), exp_result);
    check({tag, "_prb"}, int'(bus.probes), exp_probes);
    @(negedge clk);
    check({tag, "_pulse"}, int'(bus.done), 0);
    if (bad_probe == 0) check({tag, "_hold"}, int'(bus.guess), exp_result);
  endtask

  initial begin
    bus.start = 1'b0;
    // Reset values
    #12;
    check("rst_guess", int'(bus.guess), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_result", int'(bus.result), 0);
    check("rst_probes", int'(bus.probes), 0);
    check("rst_err", int'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", int'(bus.busy), 0);
    check("idle_done", int'(bus.done), 0);

    run("t5", 5, 16'h8465, 4, 5, 4, 1'b0, 0);
    run("t8", 8, 16'h8000, 1, 8, 1, 1'b0, 0);
    run("t0", 0, 16'h8421, 4, 0, 4, 1'b0, 0);
    run("t15", 15, 16'h8CEF, 4, 15, 4, 1'b0, 0);
    run("poke", 5, 16'h8465, 4, 5, 4, 1'b1, 0);

    // Reset during probe 2 aborts at once with no done
    tgt = 5;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_guess", int'(bus.guess), 4);
    #2 rst_n = 1'b0;
    #1;
    check("mid_busy", int'(bus.busy), 0);
    check("mid_done", int'(bus.done), 0);
    check("mid_gclr", int'(bus.guess), 0);
    @(negedge clk);
    check("mid_nodone", int'(bus.done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_idle", int'(bus.busy), 0);

`ifdef SAR_ONEHOT_CHECK_EN
    run("viol", 5, 16'h8400, 2, 0, 2, 1'b0, 2);
    check("viol_err", int'(bus.err), 1);
    @(negedge clk);
    check("viol_sticky", int'(bus.err), 1);
    run("clr", 8, 16'h8000, 1, 8, 1, 1'b0, 0);
    check("clr_err", int'(bus.err), 0);
`else
    run("viol", 5, 16'h8423, 4, 3, 4, 1'b0, 2);
    check("viol_err", int'(bus.err), 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
